axil_ram_ctrl: RTL and testbench
================================

# axil_ram_ctrl

AXI4-Lite responder that acts as the initiator on one native port of the banked dual-port RAM. It accepts single-beat AXI4-Lite reads and writes from the system interconnect. It converts each one into a single RAM port cycle (`ram_en`/`ram_we`/`ram_addr`/`ram_din`) and returns the matching B or R response. One instance drives port A of the RAM; a second instance may drive port B.

## Interface
- `RAM_ADDR_W`, default 5: RAM word-address width (32 entries).
- `RAM_DATA_W`, default 8: RAM data width; must be ≤ 32.
- `AXI_ADDR_W`, default 12: AXI byte-address width; must be ≥ `RAM_ADDR_W`+2.
- `clka` input 1: sole clock; RAM port and AXI side share it.
- `rsta` input 1: reset, asynchronous, active-high.
- `s_awaddr` input `AXI_ADDR_W`; `s_awvalid` input 1; `s_awready` output 1.
- `s_wdata` input 32; `s_wstrb` input 4; `s_wvalid` input 1; `s_wready` output 1.
- `s_bresp` output 2; `s_bvalid` output 1; `s_bready` input 1.
- `s_araddr` input `AXI_ADDR_W`; `s_arvalid` input 1; `s_arready` output 1.
- `s_rdata` output 32; `s_rresp` output 2; `s_rvalid` output 1; `s_rready` input 1.
- `ram_en` output 1; `ram_we` output 1; `ram_addr` output `RAM_ADDR_W`; `ram_din` output `RAM_DATA_W`: RAM port drive.
- `ram_dout` input `RAM_DATA_W`: RAM read data, valid one cycle after an `ram_en`=1, `ram_we`=0 cycle.

## Operation
- Word mapping: RAM entry k is at byte address 4k; `ram_addr` = addr[`RAM_ADDR_W`+1:2].
- FSM states: IDLE, WR_EXEC, WR_RESP, RD_EXEC, RD_CAP, RD_RESP.
- Only one transaction is in flight at a time; no outstanding pipelining.
- **IDLE** (write request = `s_awvalid` && `s_wvalid`; read request = `s_arvalid`):
  - Write request only: `s_awready`=`s_wready`=1 for one cycle; latch address, `s_wdata`[`RAM_DATA_W`-1:0] and `s_wstrb`[0]; go to WR_EXEC.
  - Read request only: `s_arready`=1; latch address; go to RD_EXEC.
  - Both requests: round-robin on a `last_was_wr` flag. After reset the write wins.
  - A lone AW or lone W is not accepted; it waits for its partner.
- **WR_EXEC**: `ram_en`=1, `ram_we`=`wstrb[0]`. If `wstrb[0]`=0, no RAM write occurs but the response is still OKAY. Go to WR_RESP.
- **WR_RESP**: `s_bvalid`=1 held until `s_bready`, then return to IDLE.
- **RD_EXEC**: `ram_en`=1, `ram_we`=0; go to RD_CAP.
- **RD_CAP**: capture `ram_dout`, zero-extended to 32 bits, into the `s_rdata` register; go to RD_RESP.
- **RD_RESP**: `s_rvalid`=1 held until `s_rready`, then return to IDLE.
- `s_rdata` and `s_bresp`/`s_rresp` stay stable while their valid is high.
- `ram_en` is 0 in all states except WR_EXEC and RD_EXEC. `ram_addr`/`ram_din` hold their last latched value.
- Reset mid-transaction aborts it: the FSM goes to IDLE, all valids drop, and no RAM cycle is issued.

## Timing
- Reset values: all `*ready`, `*valid`, `ram_en`, `ram_we` are 0; `s_bresp`, `s_rresp`, `s_rdata`, `ram_addr`, `ram_din` are 0.
- `*ready` signals are combinational from state and valids; all other outputs are registered.
- Write: AW/W handshake at edge N; `ram_en` high in cycle N+1; `s_bvalid` high from N+2.
- Read: AR handshake at edge N; `ram_en` in N+1; `ram_dout` sampled in N+2; `s_rvalid` high from N+3.
- Back-to-back: a new handshake is possible in the cycle after B/R completes. Minimum spacing is 3 cycles per write and 4 per read with `s_bready`/`s_rready` tied high.

## Configuration
- `AXIL_RAM_SLVERR_EN` defined:
  - Address bits above `RAM_ADDR_W`+1 nonzero, or addr[1:0] ≠ 0, give response SLVERR (2'b10).
  - Such accesses issue no RAM cycle: WR_EXEC/RD_EXEC keep `ram_en`=0, and `s_rdata`=0.
- Undefined: upper bits and addr[1:0] are ignored (aliasing); the response is always OKAY.

## Structure
- Package `axil_ram_pkg`:
  - `resp_t` constants `RESP_OKAY`=2'b00, `RESP_SLVERR`=2'b10.
  - `state_t` enum for the six states.
- Single module; the arbiter is a one-bit flag, so no sub-module is needed.

## Test plan
- Reset: assert `rsta` → all outputs 0, FSM in IDLE.
- Write then read: write 0x0000_00A5 to 0x04C → `ram_addr`=19, `ram_din`=0xA5, `ram_we`=1 in cycle N+1; BRESP OKAY. Read of 0x04C → `s_rdata`=0x0000_00A5 at N+3.
- Strobe off: write 0x3C with `s_wstrb`=4'b0000 → `ram_we`=0, BRESP OKAY; a read returns the old value.
- Simultaneous AW/W/AR three times in a row → grants are write, read, write. Then hold `s_rready`=0 for 5 cycles → `s_rdata` is held stable.
- With `AXIL_RAM_SLVERR_EN`, read 0x080 and write 0x002 → SLVERR, `ram_en` never 1. Without the macro, 0x080 aliases entry 0 and returns OKAY.
- Reset asserted in RD_CAP → `s_rvalid` never rises; a following write completes normally.

Source files
------------

// File: rtl/axil_ram_pkg.sv
// Shared types for the AXI4-Lite to RAM-port controller.
// Response codes and controller FSM states.
package axil_ram_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_EXEC,
        WR_RESP,
        RD_EXEC,
        RD_CAP,
        RD_RESP
    } state_t;

endpackage

// File: rtl/axil_ram_ctrl.sv
// AXI4-Lite responder driving one native port of the banked dual-port RAM.
// Define AXIL_RAM_SLVERR_EN to reject out-of-range/unaligned addresses with SLVERR.
module axil_ram_ctrl
    import axil_ram_pkg::*;
#(
    parameter int RAM_ADDR_W = 5,
    parameter int RAM_DATA_W = 8,
    parameter int AXI_ADDR_W = 12
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic [AXI_ADDR_W-1:0] s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [AXI_ADDR_W-1:0] s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [RAM_DATA_W-1:0] ram_din,
    input  logic [RAM_DATA_W-1:0] ram_dout
);

    state_t state, next;
    logic   last_was_wr;
    logic   err;
    logic   wr_req, rd_req;
    logic   grant_wr, grant_rd;
    logic   aw_err, ar_err;
    logic   unused_bits;

    assign wr_req = s_awvalid && s_wvalid;
    assign rd_req = s_arvalid;

`ifdef AXIL_RAM_SLVERR_EN
    assign aw_err = ((s_awaddr >> (RAM_ADDR_W + 2)) != '0)
                 || (s_awaddr[1:0] != 2'b00);
    assign ar_err = ((s_araddr >> (RAM_ADDR_W + 2)) != '0)
                 || (s_araddr[1:0] != 2'b00);
`else
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;
`endif

    // Address bits outside the word index and upper data/strobe lanes are don't-care.
    assign unused_bits = ^{s_awaddr, s_araddr, s_wdata, s_wstrb};

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) state <= IDLE;
        else      state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (grant_wr)      next = WR_EXEC;
                else if (grant_rd) next = RD_EXEC;
            end
            WR_EXEC: next = WR_RESP;
            WR_RESP: if (s_bready) next = IDLE;
            RD_EXEC: next = RD_CAP;
            RD_CAP:  next = RD_RESP;
            RD_RESP: if (s_rready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        if (state == IDLE) begin
            grant_wr = wr_req && (!rd_req || !last_was_wr);
            grant_rd = rd_req && (!wr_req || last_was_wr);
        end
        s_awready = grant_wr;
        s_wready  = grant_wr;
        s_arready = grant_rd;
    end

    // RAM drive is set on the grant edge so ram_en is a clean register in the EXEC cycle.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            last_was_wr <= 1'b0;
            err         <= 1'b0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_din     <= '0;
            s_bvalid    <= 1'b0;
            s_bresp     <= RESP_OKAY;
            s_rvalid    <= 1'b0;
            s_rresp     <= RESP_OKAY;
            s_rdata     <= '0;
        end else begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_wr) begin
                        last_was_wr <= 1'b1;
                        err         <= aw_err;
                        ram_addr    <= s_awaddr[RAM_ADDR_W+1:2];
                        ram_din     <= s_wdata[RAM_DATA_W-1:0];
                        ram_en      <= !aw_err;
                        ram_we      <= s_wstrb[0] && !aw_err;
                    end else if (grant_rd) begin
                        last_was_wr <= 1'b0;
                        err         <= ar_err;
                        ram_addr    <= s_araddr[RAM_ADDR_W+1:2];
                        ram_en      <= !ar_err;
                    end
                end
                WR_EXEC: begin
                    s_bvalid <= 1'b1;
                    s_bresp  <= err ? RESP_SLVERR : RESP_OKAY;
                end
                WR_RESP: if (s_bready) s_bvalid <= 1'b0;
                RD_EXEC: ;
                RD_CAP: begin
                    s_rvalid <= 1'b1;
                    s_rresp  <= err ? RESP_SLVERR : RESP_OKAY;
                    s_rdata  <= err ? 32'h0 : 32'(ram_dout);
                end
                RD_RESP: if (s_rready) s_rvalid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_ram_ctrl.sv
// Directed self-checking bench for axil_ram_ctrl with a behavioral RAM port.
// Covers AXIL_RAM_SLVERR_EN in both builds via matching conditional steps.
module tb_axil_ram_ctrl;

    logic        clka = 1'b0;
    logic        rsta;
    logic [11:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [11:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic        ram_en;
    logic        ram_we;
    logic [4:0]  ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;

    logic [7:0]  mem [32];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clka = ~clka;

    axil_ram_ctrl dut (
        .clka      (clka),
        .rsta      (rsta),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // Behavioral RAM port: read data valid one cycle after a read enable.
    always @(posedge clka) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input string tag, input logic [11:0] addr,
                            input logic [31:0] data, input logic [3:0] strb,
                            input logic e_en, input logic e_we,
                            input logic [4:0] e_addr, input logic [7:0] e_din,
                            input logic [1:0] e_resp);
        @(negedge clka);
        s_awaddr  = addr;
        s_wdata   = data;
        s_wstrb   = strb;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        s_bready  = 1'b1;
        #1;
        chk({tag, "_awready"}, 32'(s_awready), 32'd1);
        @(posedge clka);
        #1;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        chk({tag, "_en"}, 32'(ram_en), 32'(e_en));
        chk({tag, "_we"}, 32'(ram_we), 32'(e_we));
        chk({tag, "_addr"}, 32'(ram_addr), 32'(e_addr));
        chk({tag, "_din"}, 32'(ram_din), 32'(e_din));
        @(posedge clka);
        #1;
        chk({tag, "_bvalid"}, 32'(s_bvalid), 32'd1);
        chk({tag, "_bresp"}, 32'(s_bresp), 32'(e_resp));
        chk({tag, "_en_off"}, 32'(ram_en), 32'd0);
        @(posedge clka);
        #1;
        chk({tag, "_bdone"}, 32'(s_bvalid), 32'd0);
    endtask

    task automatic do_read(input string tag, input logic [11:0] addr,
                           input logic e_en, input logic [4:0] e_addr,
                           input logic [31:0] e_data, input logic [1:0] e_resp);
        @(negedge clka);
        s_araddr  = addr;
        s_arvalid = 1'b1;
        s_rready  = 1'b1;
        #1;
        chk({tag, "_arready"}, 32'(s_arready), 32'd1);
        @(posedge clka);
        #1;
        s_arvalid = 1'b0;
        chk({tag, "_en"}, 32'(ram_en), 32'(e_en));
        chk({tag, "_we"}, 32'(ram_we), 32'd0);
        chk({tag, "_addr"}, 32'(ram_addr), 32'(e_addr));
        @(posedge clka);
        #1;
        chk({tag, "_early"}, 32'(s_rvalid), 32'd0);
        @(posedge clka);
        #1;
        chk({tag, "_rvalid"}, 32'(s_rvalid), 32'd1);
        chk({tag, "_rdata"}, s_rdata, e_data);
        chk({tag, "_rresp"}, 32'(s_rresp), 32'(e_resp));
        @(posedge clka);
        #1;
        chk({tag, "_rdone"}, 32'(s_rvalid), 32'd0);
    endtask

    task automatic wait_grant(input string tag, input logic e_wr);
        int k = 0;
        while (!(s_awready || s_arready) && k < 10) begin
            @(negedge clka);
            #1;
            k++;
        end
        chk({tag, "_bound"}, 32'(k < 10), 32'd1);
        chk({tag, "_aw"}, 32'(s_awready), 32'(e_wr));
        chk({tag, "_ar"}, 32'(s_arready), 32'(!e_wr));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic seen;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        ram_dout  = 8'h00;
        rsta      = 1'b1;
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        repeat (3) @(posedge clka);
        #1;
        chk("rst_awready", 32'(s_awready), 32'd0);
        chk("rst_arready", 32'(s_arready), 32'd0);
        chk("rst_bvalid", 32'(s_bvalid), 32'd0);
        chk("rst_rvalid", 32'(s_rvalid), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_resp", 32'({s_bresp, s_rresp}), 32'd0);
        chk("rst_rdata", s_rdata, 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", 32'(ram_din), 32'd0);
        @(negedge clka);
        rsta = 1'b0;

        do_write("wr_a5", 12'h04C, 32'h0000_00A5, 4'hF, 1, 1, 5'd19, 8'hA5, 2'b00);
        do_read("rd_a5", 12'h04C, 1, 5'd19, 32'h0000_00A5, 2'b00);

        do_write("wr_5a", 12'h03C, 32'h0000_005A, 4'hF, 1, 1, 5'd15, 8'h5A, 2'b00);
        do_write("wr_nostrb", 12'h03C, 32'h0000_0077, 4'h0, 1, 0, 5'd15, 8'h77, 2'b00);
        do_read("rd_nostrb", 12'h03C, 1, 5'd15, 32'h0000_005A, 2'b00);

        @(negedge clka);
        s_awaddr  = 12'h010;
        s_wdata   = 32'h0000_0011;
        s_wstrb   = 4'hF;
        s_araddr  = 12'h04C;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        s_arvalid = 1'b1;
        s_bready  = 1'b1;
        s_rready  = 1'b0;
        #1;
        wait_grant("arb1", 1'b1);
        @(posedge clka);
        @(negedge clka);
        #1;
        wait_grant("arb2", 1'b0);
        @(posedge clka);
        begin
            int k = 0;
            while (!s_rvalid && k < 10) begin
                @(negedge clka);
                k++;
            end
            chk("hold_bound", 32'(k < 10), 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clka);
            chk("hold_rvalid", 32'(s_rvalid), 32'd1);
            chk("hold_rdata", s_rdata, 32'h0000_00A5);
        end
        s_rready = 1'b1;
        @(posedge clka);
        #1;
        chk("hold_rdone", 32'(s_rvalid), 32'd0);
        wait_grant("arb3", 1'b1);
        @(posedge clka);
        #1;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_arvalid = 1'b0;
        repeat (3) @(posedge clka);
        #1;
        chk("arb3_bdone", 32'(s_bvalid), 32'd0);
        do_read("rd_0x010", 12'h010, 1, 5'd4, 32'h0000_0011, 2'b00);

        do_write("wr_e0", 12'h000, 32'h0000_003E, 4'hF, 1, 1, 5'd0, 8'h3E, 2'b00);
`ifdef AXIL_RAM_SLVERR_EN
        do_read("rd_oor", 12'h080, 0, 5'd0, 32'h0, 2'b10);
        do_write("wr_unal", 12'h002, 32'h0000_0099, 4'hF, 0, 0, 5'd0, 8'h99, 2'b10);
        do_read("rd_e0", 12'h000, 1, 5'd0, 32'h0000_003E, 2'b00);
`else
        do_read("rd_alias", 12'h080, 1, 5'd0, 32'h0000_003E, 2'b00);
`endif

        @(negedge clka);
        s_araddr  = 12'h04C;
        s_arvalid = 1'b1;
        s_rready  = 1'b1;
        @(posedge clka);
        #1;
        s_arvalid = 1'b0;
        @(posedge clka);
        #1;
        rsta = 1'b1;
        #1;
        chk("abort_rvalid", 32'(s_rvalid), 32'd0);
        @(posedge clka);
        #1;
        chk("abort_en", 32'(ram_en), 32'd0);
        @(negedge clka);
        rsta = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clka);
            seen = seen | s_rvalid;
        end
        chk("abort_no_rvalid", 32'(seen), 32'd0);
        do_write("wr_after", 12'h050, 32'h0000_0042, 4'hF, 1, 1, 5'd20, 8'h42, 2'b00);
        do_read("rd_after", 12'h050, 1, 5'd20, 32'h0000_0042, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
